// File: rtl/bscan_pad_ctrl.sv
// Boundary-scan sequencer for NPADS output pads: functional/EXTEST mux plus capture/shift/update chain control.
// Latency: NOP/RELEASE 1 cycle, SAMPLE 2*NPADS+2, SCAN 2*NPADS+3 from acceptance to done.
// Backpressure: cmd_ready is low while busy. Optional abort port pair under `BSCAN_ABORT_EN`.
module bscan_pad_ctrl #(
  parameter int NPADS = 8,
  parameter int CW    = $clog2(2*NPADS)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef BSCAN_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic             si,
  output logic             so,
  input  logic [NPADS-1:0] func_do,
  input  logic [NPADS-1:0] func_oe,
  input  logic [NPADS-1:0] pad_di,
  output logic [NPADS-1:0] pad_do,
  output logic [NPADS-1:0] pad_oe,
  output logic             extest,
  output logic             busy,
  output logic             done
);

  localparam int CL = 2 * NPADS;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_SCAN    = 2'b01;
  localparam logic [1:0] OP_SAMPLE  = 2'b10;
  localparam logic [1:0] OP_RELEASE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_UPDATE,
    S_FIN
  } state_t;

  state_t           state, state_nxt;
  logic [CL-1:0]    chain, cap_vec;
  logic [CW-1:0]    cnt;
  logic [NPADS-1:0] upd_do, upd_oe;
  logic             extest_q;
  logic             is_scan;
  logic             accept;
  logic             last_shift;
  logic             abort_req;

`ifdef BSCAN_ABORT_EN
  logic aborted_q;

  assign abort_req = abort && (state == S_CAPTURE || state == S_SHIFT);

  // Remembers that this sequence ended early so the flag can pulse with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted_q <= 1'b0;
    end else if (abort_req) begin
      aborted_q <= 1'b1;
    end else if (state == S_FIN) begin
      aborted_q <= 1'b0;
    end
  end

  assign aborted = aborted_q && (state == S_FIN);
`else
  assign abort_req = 1'b0;
`endif

  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FIN);
  assign accept     = cmd_valid && cmd_ready;
  assign last_shift = (cnt == CW'(CL-1));
  assign so         = chain[0];
  assign extest     = extest_q;

  assign pad_do = extest_q ? upd_do : func_do;
  assign pad_oe = extest_q ? upd_oe : func_oe;

  // Capture sees whatever is currently on the pad enables, scan-driven or not.
  always_comb begin
    cap_vec = '0;
    for (int i = 0; i < NPADS; i++) begin
      cap_vec[2*i]   = pad_di[i];
      cap_vec[2*i+1] = pad_oe[i];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_NOP, OP_RELEASE: state_nxt = S_FIN;
            OP_SCAN, OP_SAMPLE: state_nxt = S_CAPTURE;
            default:            state_nxt = S_IDLE;
          endcase
        end
      end
      S_CAPTURE: state_nxt = abort_req ? S_FIN : S_SHIFT;
      S_SHIFT: begin
        if (abort_req) begin
          state_nxt = S_FIN;
        end else if (last_shift) begin
          state_nxt = is_scan ? S_UPDATE : S_FIN;
        end
      end
      S_UPDATE: state_nxt = S_FIN;
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain   <= '0;
      cnt     <= '0;
      is_scan <= 1'b0;
    end else begin
      if (accept) begin
        is_scan <= (cmd_op == OP_SCAN);
      end
      if (state == S_CAPTURE && !abort_req) begin
        chain <= cap_vec;
        cnt   <= '0;
      end else if (state == S_SHIFT && !abort_req) begin
        chain <= {si, chain[CL-1:1]};
        cnt   <= cnt + CW'(1);
      end
    end
  end

  // Update registers and extest move only here, so pads stay still during capture/shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_do   <= '0;
      upd_oe   <= '0;
      extest_q <= 1'b0;
    end else if (state == S_UPDATE) begin
      for (int i = 0; i < NPADS; i++) begin
        upd_do[i] <= chain[2*i];
        upd_oe[i] <= chain[2*i+1];
      end
      extest_q <= 1'b1;
    end else if (accept && cmd_op == OP_RELEASE) begin
      extest_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bscan_pad_ctrl.sv
// Directed bench for bscan_pad_ctrl with NPADS=4 (chain length 8).
// Abort checks are compiled in only when BSCAN_ABORT_EN is defined.
module tb_bscan_pad_ctrl;

  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic          cmd_ready;
  logic          si;
  logic          so;
  logic [NP-1:0] func_do, func_oe, pad_di, pad_do, pad_oe;
  logic          extest, busy, done;
`ifdef BSCAN_ABORT_EN
  logic          abort, aborted;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  so_bits;
  int          lat;
  logic        moved;

  bscan_pad_ctrl #(.NPADS(NP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef BSCAN_ABORT_EN
    .abort     (abort),
    .aborted   (aborted),
`endif
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .si        (si),
    .so        (so),
    .func_do   (func_do),
    .func_oe   (func_oe),
    .pad_di    (pad_di),
    .pad_do    (pad_do),
    .pad_oe    (pad_oe),
    .extest    (extest),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, drive si LSB-first during the shift window, record so and latency.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] si_bits,
                         output logic [7:0] so_out, output int lat_out, output logic moved_out);
    logic [NP-1:0] do0, oe0;
    int            n;
    do0       = pad_do;
    oe0       = pad_oe;
    so_out    = '0;
    moved_out = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      if (n >= 2 && n <= 9) begin
        si = si_bits[3'(n-2)];
        so_out[3'(n-2)] = so;
      end
      if (pad_do !== do0 || pad_oe !== oe0) moved_out = 1'b1;
      tick();
      n++;
    end
    si      = 1'b0;
    lat_out = n;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    si        = 1'b0;
    func_do   = 4'hA;
    func_oe   = 4'hF;
    pad_di    = 4'h0;
`ifdef BSCAN_ABORT_EN
    abort     = 1'b0;
`endif
    #22;
    chk("rst_pad_do", 32'(pad_do), 'hA);
    chk("rst_pad_oe", 32'(pad_oe), 'hF);
    chk("rst_extest", 32'(extest), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_so", 32'(so), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // SCAN: captured chain {0,1,1,1,0,1,1,1}(b7..b0 = 1011_1011), si 1100_0110 -> upd_do=A, upd_oe=9
    pad_di = 4'h5;
    run_cmd(2'b01, 8'b1100_0110, so_bits, lat, moved);
    chk("scan_so", 32'(so_bits), 'hBB);
    chk("scan_lat", 32'(lat), 11);
    chk("scan_done", 32'(done), 1);
    chk("scan_extest", 32'(extest), 1);
    func_do = 4'h0;
    func_oe = 4'h0;
    #1;
    chk("scan_pad_do", 32'(pad_do), 'hA);
    chk("scan_pad_oe", 32'(pad_oe), 'h9);
    tick();
    chk("scan_done_pulse", 32'(done), 0);
    chk("scan_ready_back", 32'(cmd_ready), 1);

    // SAMPLE while scan-driven: captures pad_di=3 and pad_oe=9 -> 1000_0111
    pad_di  = 4'h3;
    func_do = 4'h5;
    run_cmd(2'b10, 8'hFF, so_bits, lat, moved);
    chk("sample_so", 32'(so_bits), 'h87);
    chk("sample_lat", 32'(lat), 10);
    chk("sample_pads_moved", 32'(moved), 0);
    chk("sample_extest", 32'(extest), 1);
    chk("sample_pad_do", 32'(pad_do), 'hA);
    chk("sample_pad_oe", 32'(pad_oe), 'h9);
    tick();

    // SCAN aborted by reset in shift cycle 4 while pads are scan-driven
    func_do   = 4'h3;
    func_oe   = 4'hC;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    chk("midrst_busy_before", 32'(busy), 1);
    chk("midrst_pad_do_before", 32'(pad_do), 'hA);
    rst_n = 1'b0;
    #1;
    chk("midrst_pad_do", 32'(pad_do), 'h3);
    chk("midrst_pad_oe", 32'(pad_oe), 'hC);
    chk("midrst_extest", 32'(extest), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(cmd_ready), 1);
    chk("midrst_so", 32'(so), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // SCAN after reset: capture pad_di=6, pad_oe=C -> 1011_0100; si 0101_1010 -> upd_do=C, upd_oe=3
    pad_di = 4'h6;
    run_cmd(2'b01, 8'h5A, so_bits, lat, moved);
    chk("scan2_so", 32'(so_bits), 'hB4);
    chk("scan2_lat", 32'(lat), 11);
    chk("scan2_extest", 32'(extest), 1);
    chk("scan2_pad_do", 32'(pad_do), 'hC);
    chk("scan2_pad_oe", 32'(pad_oe), 'h3);
    tick();

`ifdef BSCAN_ABORT_EN
    // Abort in shift cycle 3 of a SCAN: FIN next, update registers untouched
    pad_di    = 4'hF;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_done", 32'(done), 1);
    chk("abort_aborted", 32'(aborted), 1);
    chk("abort_extest", 32'(extest), 1);
    chk("abort_pad_do", 32'(pad_do), 'hC);
    chk("abort_pad_oe", 32'(pad_oe), 'h3);
    tick();
    chk("abort_done_pulse", 32'(done), 0);
    chk("abort_aborted_pulse", 32'(aborted), 0);
    chk("abort_ready", 32'(cmd_ready), 1);
`endif

    // RELEASE: extest drops on the acceptance edge, done in the same following cycle
    run_cmd(2'b11, 8'h00, so_bits, lat, moved);
    chk("release_lat", 32'(lat), 1);
    chk("release_extest", 32'(extest), 0);
    chk("release_pad_do", 32'(pad_do), 'h3);
    chk("release_pad_oe", 32'(pad_oe), 'hC);
    tick();
    chk("release_ready", 32'(cmd_ready), 1);

    // NOP
    run_cmd(2'b00, 8'h00, so_bits, lat, moved);
    chk("nop_lat", 32'(lat), 1);
    chk("nop_extest", 32'(extest), 0);
    tick();
    chk("nop_done_pulse", 32'(done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
